segasys1_sound_cmd_latch: RTL and testbench
===========================================

# segasys1_sound_cmd_latch

Sound-side receiver for the main CPU's sound request. It captures each one-cycle `SNDRQ`/`SNDNO` command into a small FIFO and raises `NMI` to the sound Z80. The command is returned on the sound CPU data bus when the CPU reads the command window `$E000-$EFFF`. It sits between the main CPU board's sound-request output and the sound CPU data selector, and lets back-to-back main-CPU commands survive the slower sound-CPU service loop.

## Interface
Parameters:
- `AW`, default 2: FIFO address width; depth is 2^AW entries.
- `NMI_GAP`, default 4: number of `SCPU_CE` pulses `NMI` stays low after a pop before it may reassert.

Ports:
- `CLK48M`  in  1  system clock; the block's only clock.
- `RESET`  in  1  reset, synchronous, active-high.
- `SCPU_CE`  in  1  sound CPU clock enable, one `CLK48M` cycle wide.
- `SNDRQ`  in  1  command strobe from the main side, one `CLK48M` cycle wide.
- `SNDNO`  in  8  command byte; valid while `SNDRQ`=1.
- `SCPUAD`  in  16  sound CPU address.
- `SCPU_MREQ`  in  1  sound CPU memory request, active-high.
- `SCPU_RD`  in  1  sound CPU read strobe, active-high.
- `CS`  out  1  combinational; `SCPUAD[15:12]==4'hE & SCPU_MREQ`.
- `DO`  out  8  read data: FIFO head when non-empty, otherwise the last popped byte.
- `NMI`  out  1  NMI request to the sound CPU, level, registered.
- `LEVEL`  out  AW+1  FIFO occupancy, 0..2^AW.
- `OVF`  out  1  sticky flag, set when a push arrives while the FIFO is full.

## Operation
- Storage: 2^AW x 8 array, `wp`/`rp` pointers of AW bits that wrap modulo 2^AW, and an AW+1 bit count.
- Push: on a `CLK48M` edge with `SNDRQ`=1, `SNDNO` is written at `wp`.
  - Not full: `wp`+1, count+1.
  - Full and no pop this cycle: overwrite the newest entry at `wp`-1 (last writer wins), pointers and count unchanged, `OVF`<=1.
- Read detect: `rdq` is a register updated only on `SCPU_CE`, holding `CS & SCPU_RD`.
  - `rd_rise = SCPU_CE & CS & SCPU_RD & ~rdq`.
  - Exactly one pop per Z80 read cycle, regardless of wait states.
- Pop: on `rd_rise` with count>0, `hold`<=mem[rp], `rp`+1, count-1.
  - A pop with count=0 does nothing.
- Push and pop in the same cycle: both take effect and count is unchanged. This also applies when full, so there is no overwrite and `OVF` is unchanged.
- `DO` = count>0 ? mem[rp] : `hold`.
- NMI FSM:
  - IDLE (`NMI`=0): count>0 -> ARMED.
  - ARMED (`NMI`=1): `rd_rise` -> GAP with `gcnt`<=0.
  - GAP (`NMI`=0): `gcnt`+1 on each `SCPU_CE`; at `gcnt`==NMI_GAP-1 with `SCPU_CE` -> IDLE.
- Each pending command therefore produces a fresh `NMI` rising edge.
- `NMI` is a registered output of the FSM state.

## Timing
- Reset values: count=0, `wp`=`rp`=0, `hold`=8'h00, `DO`=8'h00, `NMI`=0, `OVF`=0, `LEVEL`=0, FSM=IDLE, `rdq`=0, `gcnt`=0.
- `RESET` overrides any simultaneous push or pop. Memory contents need no reset.
- Push latency: `SNDRQ` at edge N -> `LEVEL` updated after N. `NMI`=1 one edge later (N+1) when the FSM starts in IDLE.
- Pop latency: `rd_rise` at edge M -> `LEVEL`, `DO` and `NMI`=0 all update after M.
- `DO` is valid combinationally throughout the read cycle, before the pop edge.
- Minimum `NMI` low time: NMI_GAP `SCPU_CE` pulses.
- `rd_rise` in IDLE or GAP, such as a polling read: pop still occurs and the FSM state is unchanged.
- Reset mid-GAP or mid-read: returns to IDLE with an empty FIFO. A read still in progress after reset does not pop, because count=0.

## Test plan
- Single command: `SNDRQ` with `SNDNO`=8'h5A -> `LEVEL`=1, `NMI`=1 next cycle. Read `$E000` -> `DO`=5A, then `LEVEL`=0, `NMI`=0, and `NMI` stays 0 for ≥4 `SCPU_CE` pulses.
- Burst: push 8'h01..8'h03 on consecutive cycles, then read three times -> `DO` sequence 01, 02, 03. `NMI` rises again after each gap while entries remain, then stays 0 when empty. A fourth read returns `DO`=03.
- Overflow: push 8'h10..8'h14 with AW=2 -> `LEVEL`=4, `OVF`=1. Reads return 10, 11, 12, 14.
- Simultaneous: with the FIFO full, push 8'hAA in the same cycle as `rd_rise` -> `LEVEL` stays 4, `OVF` stays 0, and AA is the last entry read out.
- Wait-stated read: hold `CS & SCPU_RD` high for 6 `SCPU_CE` pulses with 2 entries -> exactly one pop, `LEVEL`=1.
- Reset in GAP: assert `RESET` for 1 cycle with `LEVEL`=2 -> all outputs at reset values next cycle, and `NMI` stays 0 with no further `SNDRQ`.

Source files
------------

// File: rtl/segasys1_sound_cmd_latch.sv
// segasys1_sound_cmd_latch: queues SNDRQ/SNDNO sound commands, raises NMI to the sound Z80 and returns the queue head on reads of $E000-$EFFF
module segasys1_sound_cmd_latch #(
  parameter int AW = 2,
  parameter int NMI_GAP = 4
) (
  input  logic        CLK48M,
  input  logic        RESET,
  input  logic        SCPU_CE,
  input  logic        SNDRQ,
  input  logic [7:0]  SNDNO,
  input  logic [15:0] SCPUAD,
  input  logic        SCPU_MREQ,
  input  logic        SCPU_RD,
  output logic        CS,
  output logic [7:0]  DO,
  output logic        NMI,
  output logic [AW:0] LEVEL,
  output logic        OVF
);
  localparam int DEPTH = 1 << AW;
  localparam int GW = $clog2(NMI_GAP + 1);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  localparam logic [GW-1:0] GLAST = GW'(NMI_GAP - 1);
  typedef enum logic [1:0] {IDLE, ARMED, GAP} st_t;
  st_t st_q, st_d;
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d, waddr;
  logic [AW:0] cnt_q, cnt_d;
  logic [7:0] hold_q, hold_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic rdq_q, rdq_d, ovf_q, ovf_d, nmi_q, nmi_d;
  logic rd_cur, rd_rise, full, pop, push_ok, over, we;
  logic addr_unused;
  always_comb begin
    addr_unused = ^SCPUAD[11:0];
    CS = (SCPUAD[15:12] == 4'hE) & SCPU_MREQ;
    rd_cur = CS & SCPU_RD;
    rd_rise = SCPU_CE & rd_cur & ~rdq_q;
    full = cnt_q == FULL;
    pop = rd_rise & (cnt_q != '0);
    push_ok = SNDRQ & (~full | pop);
    over = SNDRQ & full & ~pop;
    we = push_ok | over;
    waddr = over ? wp_q - AW'(1) : wp_q;
    wp_d = push_ok ? wp_q + AW'(1) : wp_q;
    rp_d = pop ? rp_q + AW'(1) : rp_q;
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    hold_d = pop ? mem_q[rp_q] : hold_q;
    ovf_d = ovf_q | over;
    rdq_d = SCPU_CE ? rd_cur : rdq_q;
    DO = (cnt_q != '0) ? mem_q[rp_q] : hold_q;
    LEVEL = cnt_q;
    OVF = ovf_q;
    NMI = nmi_q;
  end
  always_comb begin
    st_d = st_q;
    gcnt_d = gcnt_q;
    case (st_q)
      IDLE: st_d = (cnt_q != '0) ? ARMED : IDLE;
      ARMED: begin
        st_d = rd_rise ? GAP : ARMED;
        gcnt_d = rd_rise ? '0 : gcnt_q;
      end
      GAP: begin
        st_d = (SCPU_CE && gcnt_q == GLAST) ? IDLE : GAP;
        gcnt_d = SCPU_CE ? gcnt_q + GW'(1) : gcnt_q;
      end
      default: st_d = IDLE;
    endcase
  end
  always_comb nmi_d = st_d == ARMED;
  always_ff @(posedge CLK48M) begin
    if (RESET) begin
      st_q <= IDLE;
      gcnt_q <= '0;
      nmi_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      hold_q <= 8'h00;
      ovf_q <= 1'b0;
      rdq_q <= 1'b0;
    end else begin
      st_q <= st_d;
      gcnt_q <= gcnt_d;
      nmi_q <= nmi_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      hold_q <= hold_d;
      ovf_q <= ovf_d;
      rdq_q <= rdq_d;
    end
  end
  always_ff @(posedge CLK48M) if (we && !RESET) mem_q[waddr] <= SNDNO;
endmodule

// File: tb/tb_segasys1_sound_cmd_latch.sv
// tb_segasys1_sound_cmd_latch: vector table, directed corner sequences and random traffic against a queue model
module tb_segasys1_sound_cmd_latch;
  localparam int AW = 2, NMI_GAP = 4, DEPTH = 1 << AW;
  logic clk = 1'b0, rst = 1'b1, ce = 1'b0, rq = 1'b0, mreq = 1'b0, rdn = 1'b0;
  logic [7:0] no = 8'h00, dout;
  logic [15:0] ad = 16'h0000;
  logic cs, nmi, ovf;
  logic [AW:0] lvl;
  always #5 clk = ~clk;
  segasys1_sound_cmd_latch #(.AW(AW), .NMI_GAP(NMI_GAP)) dut (
    .CLK48M(clk), .RESET(rst), .SCPU_CE(ce), .SNDRQ(rq), .SNDNO(no),
    .SCPUAD(ad), .SCPU_MREQ(mreq), .SCPU_RD(rdn),
    .CS(cs), .DO(dout), .NMI(nmi), .LEVEL(lvl), .OVF(ovf)
  );
  int passes = 0, total = 0;
  byte unsigned q[$];
  logic [7:0] m_hold;
  bit m_ovf, m_rdq, m_nmi;
  int m_gap;
  typedef struct {
    bit rq; logic [7:0] no; bit ce; bit rd;
    int lvl; bit nmi; logic [7:0] dout; bit ovf;
  } vec_t;
  vec_t tv[10];
  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask
  function automatic int m_do();
    return q.size() > 0 ? int'(q[0]) : int'(m_hold);
  endfunction
  task automatic m_reset();
    q.delete();
    m_hold = 8'h00;
    m_ovf = 0;
    m_rdq = 0;
    m_nmi = 0;
    m_gap = 0;
  endtask
  // One clock edge of the specified behaviour, using the inputs currently driven.
  task automatic m_edge();
    bit c, r, rise, pop;
    int sz;
    c = ad[15:12] == 4'hE && mreq;
    r = c && rdn;
    rise = ce && r && !m_rdq;
    sz = q.size();
    pop = rise && sz > 0;
    if (rst) begin
      m_reset();
      return;
    end
    if (ce) m_rdq = r;
    if (m_nmi) begin
      if (rise) begin
        m_nmi = 0;
        m_gap = NMI_GAP;
      end
    end else if (m_gap > 0) begin
      if (ce) m_gap--;
    end else m_nmi = sz > 0;
    if (pop) m_hold = q.pop_front();
    if (rq) begin
      if (sz < DEPTH || pop) q.push_back(no);
      else begin
        q[q.size()-1] = no;
        m_ovf = 1;
      end
    end
  endtask
  task automatic cmp();
    chk("level", int'(lvl), q.size());
    chk("nmi", int'(nmi), int'(m_nmi));
    chk("ovf", int'(ovf), int'(m_ovf));
    chk("do", int'(dout), m_do());
    chk("cs", int'(cs), int'(ad[15:12] == 4'hE && mreq));
  endtask
  task automatic cyc_raw(input bit r, input logic [7:0] n, input bit e,
                         input logic [15:0] a, input bit m, input bit d);
    rq = r; no = n; ce = e; ad = a; mreq = m; rdn = d;
    @(posedge clk);
    m_edge();
    #1;
    cmp();
  endtask
  task automatic cyc(input bit r, input logic [7:0] n, input bit e, input bit rd);
    cyc_raw(r, n, e, rd ? 16'hE000 : 16'h0000, rd, rd);
  endtask
  task automatic do_reset();
    rst = 1;
    cyc(0, 8'h00, 0, 0);
    rst = 0;
    chk("rst_level", int'(lvl), 0);
    chk("rst_nmi", int'(nmi), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_do", int'(dout), 0);
  endtask
  task automatic wait_nmi(input string nm);
    int k = 0;
    while (!nmi && k < 40) begin
      cyc(0, 8'h00, 1, 0);
      k++;
    end
    chk(nm, int'(nmi), 1);
  endtask
  // One Z80 read: DO is checked before the pop edge, then the strobe is released.
  task automatic rd_once(input string nm, input logic [7:0] exp, input bit r, input logic [7:0] n);
    rq = r; no = n; ce = 1; ad = 16'hE000; mreq = 1; rdn = 1;
    #1;
    chk(nm, int'(dout), int'(exp));
    @(posedge clk);
    m_edge();
    #1;
    cmp();
    cyc(0, 8'h00, 1, 0);
  endtask
  initial begin
    tv[0] = '{1, 8'h5A, 0, 0, 1, 0, 8'h5A, 0};
    tv[1] = '{0, 8'h00, 0, 0, 1, 1, 8'h5A, 0};
    tv[2] = '{0, 8'h00, 1, 1, 0, 0, 8'h5A, 0};
    tv[3] = '{0, 8'h00, 1, 1, 0, 0, 8'h5A, 0};
    tv[4] = '{0, 8'h00, 1, 0, 0, 0, 8'h5A, 0};
    tv[5] = '{0, 8'h00, 1, 0, 0, 0, 8'h5A, 0};
    tv[6] = '{0, 8'h00, 1, 0, 0, 0, 8'h5A, 0};
    tv[7] = '{0, 8'h00, 0, 0, 0, 0, 8'h5A, 0};
    tv[8] = '{1, 8'h77, 0, 0, 1, 0, 8'h77, 0};
    tv[9] = '{0, 8'h00, 0, 0, 1, 1, 8'h77, 0};
    m_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(tv[i].rq, tv[i].no, tv[i].ce, tv[i].rd);
      chk($sformatf("tv%0d_level", i), int'(lvl), tv[i].lvl);
      chk($sformatf("tv%0d_nmi", i), int'(nmi), int'(tv[i].nmi));
      chk($sformatf("tv%0d_do", i), int'(dout), int'(tv[i].dout));
      chk($sformatf("tv%0d_ovf", i), int'(ovf), int'(tv[i].ovf));
    end
    do_reset();
    for (int i = 1; i <= 3; i++) cyc(1, 8'(i), 0, 0);
    chk("burst_level", int'(lvl), 3);
    for (int i = 1; i <= 3; i++) begin
      wait_nmi("burst_nmi");
      rd_once("burst_do", 8'(i), 0, 8'h00);
    end
    for (int i = 0; i < 12; i++) cyc(0, 8'h00, 1, 0);
    chk("burst_empty_nmi", int'(nmi), 0);
    chk("burst_empty_level", int'(lvl), 0);
    rd_once("burst_4th_do", 8'h03, 0, 8'h00);
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 8'h10 + 8'(i), 0, 0);
    chk("ovf_level", int'(lvl), 4);
    chk("ovf_flag", int'(ovf), 1);
    wait_nmi("ovf_nmi0");
    rd_once("ovf_do0", 8'h10, 0, 8'h00);
    wait_nmi("ovf_nmi1");
    rd_once("ovf_do1", 8'h11, 0, 8'h00);
    wait_nmi("ovf_nmi2");
    rd_once("ovf_do2", 8'h12, 0, 8'h00);
    wait_nmi("ovf_nmi3");
    rd_once("ovf_do3", 8'h14, 0, 8'h00);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 8'h20 + 8'(i), 0, 0);
    wait_nmi("sim_nmi");
    rd_once("sim_do0", 8'h20, 1, 8'hAA);
    chk("sim_level", int'(lvl), 4);
    chk("sim_ovf", int'(ovf), 0);
    for (int i = 1; i < 4; i++) begin
      wait_nmi("sim_nmi_n");
      rd_once("sim_do", 8'h20 + 8'(i), 0, 8'h00);
    end
    wait_nmi("sim_nmi_last");
    rd_once("sim_last", 8'hAA, 0, 8'h00);
    do_reset();
    cyc(1, 8'h30, 0, 0);
    cyc(1, 8'h31, 0, 0);
    wait_nmi("ws_nmi");
    for (int i = 0; i < 6; i++) begin
      cyc(0, 8'h00, 1, 1);
      cyc(0, 8'h00, 0, 1);
    end
    cyc(0, 8'h00, 1, 0);
    chk("ws_level", int'(lvl), 1);
    chk("ws_do", int'(dout), 8'h31);
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 8'h40 + 8'(i), 0, 0);
    wait_nmi("gap_nmi");
    rd_once("gap_do", 8'h40, 0, 8'h00);
    chk("gap_level", int'(lvl), 2);
    do_reset();
    for (int i = 0; i < 20; i++) cyc(0, 8'h00, 1, 0);
    chk("gap_rst_nmi", int'(nmi), 0);
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 299) == 0;
      cyc_raw($urandom_range(0, 4) == 0, 8'($urandom), $urandom_range(0, 3) == 0,
              $urandom_range(0, 1) ? {4'hE, 12'($urandom)} : 16'($urandom),
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end
    rst = 0;
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
